// File: rtl/spu_pipe_pkg.sv
// Shared types and helpers for the result-tracking pipeline.
// One entry carries a result from execute toward write-back.
package spu_pipe_pkg;

  localparam int REG_ADDR_W = 7;
  localparam int REG_DATA_W = 128;
  localparam int STAGE_W    = 4;

  typedef struct packed {
    logic                         wr;
    logic [REG_ADDR_W-1:0]        target;
    logic signed [REG_DATA_W-1:0] value;
    logic [STAGE_W-1:0]           fw_stage;
  } pipe_entry_t;

  // Clamp the ready stage into 1..depth so slot compares stay simple.
  function automatic logic [STAGE_W-1:0] norm_stage(
    input logic [STAGE_W-1:0] s,
    input int                 depth
  );
    if (s == '0)
      return STAGE_W'(1);
    if (int'(s) > depth)
      return STAGE_W'(depth);
    return s;
  endfunction

endpackage

// File: rtl/fwd_lookup.sv
// Forwarding lookup for one source operand.
// Youngest matching slot decides: ready supplies, not-ready stalls.
module fwd_lookup
  import spu_pipe_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  pipe_entry_t [DEPTH-1:0] slots,
  input  logic [REG_ADDR_W-1:0]   src,
  input  logic                    used,
  output logic                    hit,
  output logic [REG_DATA_W-1:0]   value,
  output logic                    stall
);

  logic                  match;
  logic                  rdy;
  logic [REG_DATA_W-1:0] val;

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    match = 1'b0;
    rdy   = 1'b0;
    val   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slots[i].wr && slots[i].target == src) begin
        match = 1'b1;
        rdy   = STAGE_W'(i + 1) >= slots[i].fw_stage;
        val   = slots[i].value;
      end
    end
  end

  assign hit   = used & match & rdy;
  assign stall = used & match & ~rdy;
  assign value = hit ? val : '0;

endmodule

// File: rtl/result_pipe_fwd.sv
// Result pipeline from execute to write-back with operand forwarding.
// slot[0] is slot 1 (youngest); slot[DEPTH-1] feeds write-back.
module result_pipe_fwd
  import spu_pipe_pkg::*;
#(
  parameter int DEPTH   = 7,
  parameter int NUM_SRC = 3
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 RegWrIn,
  input  logic [REG_ADDR_W-1:0]                RegTargetIn,
  input  logic signed [REG_DATA_W-1:0]         RegValueIn,
  input  logic [STAGE_W-1:0]                   FWstageIn,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]   SrcReg,
  input  logic [NUM_SRC-1:0]                   SrcUsed,
  output logic [NUM_SRC-1:0]                   FwdHit,
  output logic [NUM_SRC-1:0][REG_DATA_W-1:0]   FwdValue,
  output logic                                 FwdStall,
  output logic                                 RegWrOut,
  output logic [REG_ADDR_W-1:0]                RegTargetOut,
  output logic signed [REG_DATA_W-1:0]         RegValueOut
);

  pipe_entry_t [DEPTH-1:0] slot;
  pipe_entry_t             cap;
  logic [NUM_SRC-1:0]      stall;

  always_comb begin
    cap.wr       = RegWrIn;
    cap.target   = RegTargetIn;
    cap.value    = RegValueIn;
    cap.fw_stage = norm_stage(FWstageIn, DEPTH);
  end

  // Flush clears every write enable, including the one captured now.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot <= '0;
    end else begin
      slot[0] <= cap;
      for (int k = 1; k < DEPTH; k++)
        slot[k] <= slot[k-1];
      if (flush)
        for (int k = 0; k < DEPTH; k++)
          slot[k].wr <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_lookup #(
      .DEPTH(DEPTH)
    ) u_lookup (
      .slots(slot),
      .src  (SrcReg[g]),
      .used (SrcUsed[g]),
      .hit  (FwdHit[g]),
      .value(FwdValue[g]),
      .stall(stall[g])
    );
  end

  assign FwdStall     = |stall;
  assign RegWrOut     = slot[DEPTH-1].wr;
  assign RegTargetOut = slot[DEPTH-1].target;
  assign RegValueOut  = slot[DEPTH-1].value;

endmodule
